shift_unit: RTL and testbench
=============================

# shift_unit

Pipelined, parametrised-width shift/rotate unit for the execute stage. Accepts one operation per cycle over a valid/ready handshake and performs logical left, logical right, arithmetic right, rotate left or rotate right. It spreads the log2(WIDTH) barrel-mux levels across STAGES register stages. Shift amounts of WIDTH or more are fully defined. A tag travels with each operation so the issuer can match results.

## Interface
- WIDTH, 32: data width; power of two, 8..64.
- AMT_W, 32: width of the shift-amount input.
- STAGES, 2: pipeline register stages; 1..log2(WIDTH).
- TAG_W, 4: width of the side-band tag.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept this cycle.
- in_op  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101..111 illegal.
- in_a  in  WIDTH  operand.
- in_b  in  AMT_W  shift amount, unsigned.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the result.
- out_err  out  1  the operation used an illegal op code.
- busy  out  1  any stage holds a valid entry.

## Operation
- An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Amount normalisation is combinational at entry. Let big = (in_b >= WIDTH).
  - SLL/SRL with big: result 0.
  - SRA with big: result {WIDTH{in_a[WIDTH-1]}}.
  - ROL/ROR: amount = in_b mod WIDTH.
  - Otherwise: amount = in_b[log2(WIDTH)-1:0].
- Rotates take the amount modulo WIDTH, so an amount of exactly WIDTH or any multiple returns in_a unchanged.
- Right shifts and rotates fill from a per-entry fill source:
  - SRL: zeros.
  - SRA: sign bit of in_a.
  - ROR: wrapped bits.
  - Left shifts mirror this.
- Illegal op: the result is in_a unchanged and out_err = 1, with the same latency.
- Mux-level assignment: mux level l (shift by 2^l) is placed in stage floor(l*STAGES/log2(WIDTH)). Each stage register carries valid, op, the remaining amount bits, the partial result, tag and err.
- Stall rule:
  - ready[STAGES-1] = out_ready.
  - ready[i] = !valid[i+1] || ready[i+1].
  - in_ready = !valid[0] || ready[0].
  - This is a combinational path from out_ready to in_ready; it is accepted and documented.
- A stage loads when its ready is high. Its valid becomes the upstream transfer, otherwise 0. Data registers hold while stalled.
- busy = OR of all stage valid bits.

## Timing
- Reset values: every valid bit 0, out_valid 0, out_data 0, out_tag 0, out_err 0, busy 0. in_ready is 1 during and after reset.
- Latency: an operation accepted at edge N appears with out_valid=1 after edge N+STAGES.
- Throughput: one operation per cycle when out_ready is held at 1.
- Stall: when out_ready=0, out_data, out_tag and out_err hold stable. Stages fill back to front, then in_ready drops.
- Simultaneous output transfer and new input at a full pipeline: both complete in the same cycle, with no bubble.
- Reset asserted mid-operation: all in-flight entries are discarded, no result is emitted, and outputs return to their reset values immediately (asynchronously).
- Order is strictly preserved; there is no reordering or drop.

## Structure
- Package shift_pkg:
  - op code localparams SHIFT_SLL..SHIFT_ROR;
  - function clog2w(WIDTH);
  - function stage_of_level(l, STAGES, LOG2W).
- Sub-module shift_stage, instantiated STAGES times via generate. It contains the mux levels assigned to it plus the stage register and handshake logic.
- Entry normalisation and the out_err decode live in the shift_unit top.

## Test plan
- WIDTH=32, STAGES=2, SLL a=0x0000_0001 b=31 -> out_data=0x8000_0000 exactly 2 cycles after accept, out_err=0.
- SRA a=0x8000_0000 b=4 -> 0xF800_0000. SRA b=40 -> 0xFFFF_FFFF. SRL b=40 -> 0x0000_0000.
- ROR a=0x1234_5678 b=36 -> 0x8123_4567. ROL b=32 -> 0x1234_5678.
- Back-to-back ops with tags 0..7 and out_ready low for cycles 3..6:
  - in_ready drops once the 2 stages plus the output are full;
  - results arrive in tag order 0..7 with no loss or duplication;
  - outputs are stable while stalled.
- in_op=3'b110, a=0xDEAD_BEEF -> out_data=0xDEAD_BEEF, out_err=1.
- rst_n pulsed low with 2 entries in flight -> out_valid=0 and busy=0 immediately; no result is produced after release.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared op codes and elaboration helpers for the pipelined shift/rotate unit.
package shift_pkg;

  localparam logic [2:0] SHIFT_SLL = 3'd0;
  localparam logic [2:0] SHIFT_SRL = 3'd1;
  localparam logic [2:0] SHIFT_SRA = 3'd2;
  localparam logic [2:0] SHIFT_ROL = 3'd3;
  localparam logic [2:0] SHIFT_ROR = 3'd4;

  function automatic int clog2w(input int width);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < width) r = i + 1;
    end
    return r;
  endfunction

  // Mux level l (shift by 2^l) lives in this pipeline stage.
  function automatic int stage_of_level(input int l, input int stages, input int log2w);
    return (l * stages) / log2w;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: the barrel-mux levels mapped to IDX plus its register.
// Every operation arrives here as a right shift/rotate; left ops were bit-reversed at entry.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int LOG2W  = 5,
  parameter int TAG_W  = 4,
  parameter int STAGES = 2,
  parameter int IDX    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             up_valid,
  input  logic [2:0]       up_op,
  input  logic [LOG2W-1:0] up_amt,
  input  logic [WIDTH-1:0] up_data,
  input  logic [TAG_W-1:0] up_tag,
  input  logic             up_err,
  output logic             valid,
  output logic [2:0]       op,
  output logic [LOG2W-1:0] amt,
  output logic [WIDTH-1:0] data,
  output logic [TAG_W-1:0] tag,
  output logic             err
);

  logic             rot;
  logic             fill;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    rot     = (up_op == SHIFT_ROL) || (up_op == SHIFT_ROR);
    fill    = (up_op == SHIFT_SRA) && up_data[WIDTH-1];
    shifted = up_data;
    for (int l = 0; l < LOG2W; l++) begin
      if (stage_of_level(l, STAGES, LOG2W) == IDX && up_amt[l]) begin
        if (rot)
          shifted = (shifted >> (1 << l)) | (shifted << (WIDTH - (1 << l)));
        else
          shifted = (shifted >> (1 << l)) | (fill ? ~({WIDTH{1'b1}} >> (1 << l)) : '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      op    <= '0;
      amt   <= '0;
      data  <= '0;
      tag   <= '0;
      err   <= 1'b0;
    end else if (load) begin
      valid <= up_valid;
      op    <= up_op;
      amt   <= up_amt;
      data  <= shifted;
      tag   <= up_tag;
      err   <= up_err;
    end
  end

endmodule

// File: rtl/shift_unit.sv
// Pipelined shift/rotate unit: entry normalisation, STAGES mux stages, output register.
// Result appears STAGES edges after accept; out_ready feeds combinationally back to in_ready.
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int AMT_W  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [AMT_W-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             busy
);

  localparam int LOG2W = clog2w(WIDTH);

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  logic             big;
  logic [LOG2W-1:0] e_amt;
  logic [WIDTH-1:0] e_data;
  logic             e_err;

  logic [STAGES-1:0] vld_s;
  logic [STAGES-1:0] ld;
  logic [2:0]        op_s   [STAGES];
  logic [LOG2W-1:0]  amt_s  [STAGES];
  logic [WIDTH-1:0]  data_s [STAGES];
  logic [TAG_W-1:0]  tag_s  [STAGES];
  logic              err_s  [STAGES];

  logic             out_ld;
  logic [WIDTH-1:0] fin_data;
  logic [LOG2W-1:0] unused_amt;

  // Saturating cases are resolved here so the stages only ever see amounts below WIDTH.
  always_comb begin
    big    = |(in_b >> LOG2W);
    e_amt  = in_b[LOG2W-1:0];
    e_data = in_a;
    e_err  = 1'b0;
    case (in_op)
      SHIFT_SLL: begin
        e_data = big ? '0 : bit_rev(in_a);
        if (big) e_amt = '0;
      end
      SHIFT_SRL: begin
        if (big) begin
          e_data = '0;
          e_amt  = '0;
        end
      end
      SHIFT_SRA: begin
        if (big) begin
          e_data = {WIDTH{in_a[WIDTH-1]}};
          e_amt  = '0;
        end
      end
      SHIFT_ROL: e_data = bit_rev(in_a);
      SHIFT_ROR: e_data = in_a;
      default: begin
        e_amt = '0;
        e_err = 1'b1;
      end
    endcase
  end

  assign out_ld = !out_valid || out_ready;

  // A stage may load when it is empty or its downstream neighbour loads this cycle.
  always_comb begin
    logic r;
    ld = '0;
    r  = out_ld;
    for (int i = STAGES - 1; i >= 0; i--) begin
      r     = !vld_s[i] || r;
      ld[i] = r;
    end
  end

  assign in_ready = ld[0];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic             up_valid;
    logic [2:0]       up_op;
    logic [LOG2W-1:0] up_amt;
    logic [WIDTH-1:0] up_data;
    logic [TAG_W-1:0] up_tag;
    logic             up_err;

    if (g == 0) begin : g_first
      assign up_valid = in_valid;
      assign up_op    = in_op;
      assign up_amt   = e_amt;
      assign up_data  = e_data;
      assign up_tag   = in_tag;
      assign up_err   = e_err;
    end else begin : g_next
      assign up_valid = vld_s[g-1];
      assign up_op    = op_s[g-1];
      assign up_amt   = amt_s[g-1];
      assign up_data  = data_s[g-1];
      assign up_tag   = tag_s[g-1];
      assign up_err   = err_s[g-1];
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .LOG2W (LOG2W),
      .TAG_W (TAG_W),
      .STAGES(STAGES),
      .IDX   (g)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (ld[g]),
      .up_valid(up_valid),
      .up_op   (up_op),
      .up_amt  (up_amt),
      .up_data (up_data),
      .up_tag  (up_tag),
      .up_err  (up_err),
      .valid   (vld_s[g]),
      .op      (op_s[g]),
      .amt     (amt_s[g]),
      .data    (data_s[g]),
      .tag     (tag_s[g]),
      .err     (err_s[g])
    );
  end

  assign unused_amt = amt_s[STAGES-1];

  always_comb begin
    fin_data = data_s[STAGES-1];
    if (op_s[STAGES-1] == SHIFT_SLL || op_s[STAGES-1] == SHIFT_ROL)
      fin_data = bit_rev(data_s[STAGES-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else if (out_ld) begin
      out_valid <= vld_s[STAGES-1];
      out_data  <= fin_data;
      out_tag   <= tag_s[STAGES-1];
      out_err   <= err_s[STAGES-1];
    end
  end

  assign busy = (|vld_s) || out_valid;

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: directed table, stall/order sequence, reset abort, random scoreboard.
module tb_shift_unit;

  localparam int WIDTH  = 32;
  localparam int AMT_W  = 32;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [AMT_W-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic             busy;

  always #5 clk = ~clk;

  shift_unit #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W),
    .STAGES(STAGES),
    .TAG_W (TAG_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag),
    .out_err  (out_err),
    .busy     (busy)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic             err;
    logic [31:0]      data;
  } exp_t;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference result straight from the operation definitions.
  function automatic exp_t ref_op(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [TAG_W-1:0] tag);
    exp_t e;
    logic signed [31:0] sa;
    int s;
    sa = a;
    s  = int'(b % 32);
    e.tag = tag;
    e.err = 1'b0;
    case (op)
      3'd0: e.data = (b >= 32) ? 32'h0 : (a << b);
      3'd1: e.data = (b >= 32) ? 32'h0 : (a >> b);
      3'd2: begin
        if (b >= 32) e.data = a[31] ? 32'hFFFF_FFFF : 32'h0;
        else         e.data = sa >>> b;
      end
      3'd3: e.data = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
      3'd4: e.data = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
      default: begin
        e.data = a;
        e.err  = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    logic [TAG_W-1:0] t;
    t = TAG_W'(idx);
    @(negedge clk);
    in_valid  = 1'b1;
    in_op     = v.op;
    in_a      = v.a;
    in_b      = v.b;
    in_tag    = t;
    out_ready = 1'b1;
    #1 check($sformatf("vec%0d_in_ready", idx), 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check($sformatf("vec%0d_not_early", idx), 64'(out_valid), 64'd0);
    @(negedge clk);
    check($sformatf("vec%0d_valid", idx), 64'(out_valid), 64'd1);
    check($sformatf("vec%0d_data", idx), 64'(out_data), 64'(v.exp));
    check($sformatf("vec%0d_err", idx), 64'(out_err), 64'(v.err));
    check($sformatf("vec%0d_tag", idx), 64'(out_tag), 64'(t));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[12];
    exp_t q[$];
    exp_t e;

    vecs[0]  = '{3'd0, 32'h0000_0001, 32'd31,        32'h8000_0000, 1'b0};
    vecs[1]  = '{3'd2, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0};
    vecs[2]  = '{3'd2, 32'h8000_0000, 32'd40,        32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{3'd1, 32'hFFFF_FFFF, 32'd40,        32'h0000_0000, 1'b0};
    vecs[4]  = '{3'd4, 32'h1234_5678, 32'd36,        32'h8123_4567, 1'b0};
    vecs[5]  = '{3'd3, 32'h1234_5678, 32'd32,        32'h1234_5678, 1'b0};
    vecs[6]  = '{3'd6, 32'hDEAD_BEEF, 32'd5,         32'hDEAD_BEEF, 1'b1};
    vecs[7]  = '{3'd3, 32'h8000_0001, 32'd1,         32'h0000_0003, 1'b0};
    vecs[8]  = '{3'd1, 32'hF000_0000, 32'd28,        32'h0000_000F, 1'b0};
    vecs[9]  = '{3'd0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[10] = '{3'd2, 32'h7FFF_FFFF, 32'd31,        32'h0000_0000, 1'b0};
    vecs[11] = '{3'd5, 32'h1234_5678, 32'd3,         32'h1234_5678, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Back-to-back tags 0..7 with the consumer stalled in cycles 3..6.
    begin
      int acc;
      int got;
      logic held;
      logic [31:0] hd;
      logic [TAG_W-1:0] ht;
      logic he;
      acc  = 0;
      got  = 0;
      held = 1'b0;
      hd   = '0;
      ht   = '0;
      he   = 1'b0;
      q.delete();
      for (int c = 0; c < 60 && got < 8; c++) begin
        @(negedge clk);
        if (held) begin
          check("stall_data_stable", 64'(out_data), 64'(hd));
          check("stall_tag_stable", 64'(out_tag), 64'(ht));
          check("stall_err_stable", 64'(out_err), 64'(he));
        end
        out_ready = !(c >= 3 && c <= 6);
        in_valid  = (acc < 8);
        in_op     = 3'($urandom_range(0, 4));
        in_a      = $urandom;
        in_b      = $urandom_range(0, 40);
        in_tag    = TAG_W'(acc);
        #1;
        if (c >= 3 && c <= 6) check($sformatf("stall_in_ready_low_c%0d", c), 64'(in_ready), 64'd0);
        if (c == 7) check("stall_accepted_before_release", 64'(acc), 64'd3);
        held = out_valid && !out_ready;
        hd   = out_data;
        ht   = out_tag;
        he   = out_err;
        if (out_valid && out_ready) begin
          check("stall_order_tag", 64'(out_tag), 64'(got));
          if (q.size() > 0) begin
            e = q.pop_front();
            check("stall_data", 64'(out_data), 64'(e.data));
          end
          got++;
        end
        if (in_valid && in_ready) begin
          q.push_back(ref_op(in_op, in_a, in_b, in_tag));
          acc++;
        end
        @(posedge clk);
      end
      check("stall_all_received", 64'(got), 64'd8);
      @(negedge clk);
      check("stall_no_duplicate", 64'(out_valid), 64'd0);
    end

    // Reset with entries in flight: everything is dropped at once.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 3'd0;
    in_a      = 32'h0000_00FF;
    in_b      = 32'd4;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("abort_pre_out_valid", 64'(out_valid), 64'd1);
    check("abort_pre_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_out_data", 64'(out_data), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("abort_no_result", 64'(out_valid), 64'd0);
    end

    // Random traffic against the reference model.
    begin
      int sent;
      sent = 0;
      q.delete();
      for (int c = 0; c < 700; c++) begin
        @(negedge clk);
        in_valid  = (c < 600) && ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        in_op     = 3'($urandom_range(0, 7));
        in_a      = $urandom;
        case ($urandom_range(0, 3))
          0:       in_b = $urandom_range(0, 31);
          1:       in_b = $urandom_range(32, 70);
          2:       in_b = $urandom;
          default: in_b = 32 * $urandom_range(0, 3);
        endcase
        in_tag = TAG_W'(sent);
        #1;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            check("rand_spurious_output", 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            check("rand_data", 64'(out_data), 64'(e.data));
            check("rand_err", 64'(out_err), 64'(e.err));
            check("rand_tag", 64'(out_tag), 64'(e.tag));
          end
        end
        if (in_valid && in_ready) begin
          q.push_back(ref_op(in_op, in_a, in_b, in_tag));
          sent++;
        end
        @(posedge clk);
      end
      check("rand_drained", 64'(q.size()), 64'd0);
      @(negedge clk);
      check("rand_idle_busy", 64'(busy), 64'd0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
